// File: rtl/line_mem_responder.sv
// Line-granular stb/cyc/we/ack memory responder with a fixed programmable access latency.
// Optional read/write transaction counters are enabled by defining LINE_MEM_STATS_EN.
module line_mem_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_cyc,
  input  logic                  mem_stb,
  input  logic                  mem_we,
  input  logic [ADDR_W-1:0]     mem_adr,
  input  logic [DATA_W/8-1:0]   mem_sel,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_ack
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
`endif
);

  localparam int SEL_W = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, BUSY, ACK, RECOVER} state_t;

  state_t              state_reg;
  logic [3:0]          cnt_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   adr_reg;
  logic [SEL_W-1:0]    sel_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rd_line;
  logic                commit;
  logic                wr_en;

  // The access completes on the BUSY edge where the counter has expired and the cycle is still held.
  assign commit = (state_reg == BUSY) && mem_cyc && (cnt_reg == 4'd0);
  assign wr_en  = commit && we_reg;

  // One byte-wide bank per byte lane gives a natural byte-enable RAM.
  genvar gi;
  generate
    for (gi = 0; gi < SEL_W; gi++) begin : g_byte
      logic [7:0] bank [DEPTH];

      always_ff @(posedge clk) begin
        if (wr_en && sel_reg[gi]) begin
          bank[adr_reg] <= wdata_reg[gi*8 +: 8];
        end
      end

      assign rd_line[gi*8 +: 8] = bank[adr_reg];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      adr_reg   <= '0;
      sel_reg   <= '0;
      wdata_reg <= '0;
      mem_ack   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem_cyc && mem_stb) begin
            we_reg    <= mem_we;
            adr_reg   <= mem_adr;
            sel_reg   <= mem_sel;
            wdata_reg <= mem_wdata;
            cnt_reg   <= 4'(LATENCY - 1);
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (!mem_cyc) begin
            state_reg <= IDLE;
          end else if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            state_reg <= ACK;
            mem_ack   <= 1'b1;
            if (!we_reg) begin
              mem_rdata <= rd_line;
            end
          end
        end
        ACK: begin
          mem_ack   <= 1'b0;
          state_reg <= RECOVER;
        end
        RECOVER: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef LINE_MEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else if (commit) begin
      if (we_reg) begin
        if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
      end else begin
        if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Testbench for line_mem_responder: directed vector table, random traffic against a line model,
// reset mid-transaction, and back-to-back requests on a LATENCY=1 instance.
module tb_line_mem_responder;

  localparam int LAT = 4;
  localparam int AW  = 12;
  localparam int DW  = 128;
  localparam int SW  = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          cyc, stb, we;
  logic [AW-1:0] adr;
  logic [SW-1:0] sel;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;

  logic          b_cyc, b_stb, b_we;
  logic [AW-1:0] b_adr;
  logic [SW-1:0] b_sel;
  logic [DW-1:0] b_wdata;
  logic [DW-1:0] b_rdata;
  logic          b_ack;

`ifdef LINE_MEM_STATS_EN
  logic [31:0] rd_count, wr_count, b_rd_count, b_wr_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [DW-1:0] model [int];

  line_mem_responder #(.LATENCY(LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_cyc   (cyc),
    .mem_stb   (stb),
    .mem_we    (we),
    .mem_adr   (adr),
    .mem_sel   (sel),
    .mem_wdata (wdata),
    .mem_rdata (rdata),
    .mem_ack   (ack)
`ifdef LINE_MEM_STATS_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  line_mem_responder #(.LATENCY(1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_cyc   (b_cyc),
    .mem_stb   (b_stb),
    .mem_we    (b_we),
    .mem_adr   (b_adr),
    .mem_sel   (b_sel),
    .mem_wdata (b_wdata),
    .mem_rdata (b_rdata),
    .mem_ack   (b_ack)
`ifdef LINE_MEM_STATS_EN
    ,
    .rd_count  (b_rd_count),
    .wr_count  (b_wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issue one request on dut (called just after a rising edge with dut idle); inputs are scrambled
  // during BUSY, cyc is dropped before edge abort_at when abort_at>0.
  task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [SW-1:0] s,
                         input logic [DW-1:0] d, input int abort_at,
                         output int ack_cnt, output int ack_cyc, output logic [DW-1:0] rd);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdata = d;
    @(posedge clk); #1;
    stb = 1'b0; we = ~w; adr = AW'($urandom); sel = SW'($urandom); wdata = rand_line();
    ack_cnt = 0; ack_cyc = -1; rd = '0;
    for (int k = 1; k <= LAT + 3; k++) begin
      if (abort_at != 0 && k == abort_at) cyc = 1'b0;
      @(posedge clk); #1;
      if (ack) begin
        ack_cnt++;
        if (ack_cyc < 0) begin
          ack_cyc = k;
          rd = rdata;
        end
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (abort_at == 0) begin
      if (w) begin
        exp_wr++;
        if (!model.exists(int'(a))) model[int'(a)] = '0;
        for (int b = 0; b < SW; b++)
          if (s[b]) model[int'(a)][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        exp_rd++;
      end
    end
    $display("txn we=%0b adr=%h sel=%h abort=%0d acks=%0d ack_cyc=%0d rdata=%h",
             w, a, s, abort_at, ack_cnt, ack_cyc, rd);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [SW-1:0] sel;
    logic [DW-1:0] wdata;
    int            abort_at;
    logic          exp_ack;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  localparam int NV = 13;
  localparam logic [DW-1:0] C010 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DW-1:0] C030 = 128'h3030_3030_C0DE_0030_1234_5678_9ABC_DEF0;
  localparam logic [DW-1:0] C040 = 128'h4040_4040_0BAD_F00D_CAFE_BABE_0000_0040;
  localparam logic [DW-1:0] DEAD = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  vec_t vecs [NV];
  int ack_cnt, ack_cyc;
  logic [DW-1:0] rd;
  int ack_pos [$];
  int stray;
  logic [AW-1:0] pool [8];

  initial begin
    vecs[0]  = '{1'b1, 12'h010, 16'hFFFF, C010,          0,   1'b1, '0};
    vecs[1]  = '{1'b0, 12'h010, 16'h0000, '0,            0,   1'b1, C010};
    vecs[2]  = '{1'b1, 12'h020, 16'hFFFF, {16{8'hAA}},   0,   1'b1, '0};
    vecs[3]  = '{1'b1, 12'h020, 16'h000F, {16{8'h55}},   0,   1'b1, '0};
    vecs[4]  = '{1'b0, 12'h020, 16'h0000, '0,            0,   1'b1, {{12{8'hAA}}, {4{8'h55}}}};
    vecs[5]  = '{1'b1, 12'h030, 16'hFFFF, C030,          0,   1'b1, '0};
    vecs[6]  = '{1'b1, 12'h030, 16'hFFFF, DEAD,          2,   1'b0, '0};
    vecs[7]  = '{1'b1, 12'h030, 16'h00FF, DEAD,          LAT, 1'b0, '0};
    vecs[8]  = '{1'b0, 12'h030, 16'h0000, '0,            0,   1'b1, C030};
    vecs[9]  = '{1'b1, 12'h010, 16'h0000, {16{8'hFF}},   0,   1'b1, '0};
    vecs[10] = '{1'b0, 12'h010, 16'h0000, '0,            0,   1'b1, C010};
    vecs[11] = '{1'b1, 12'h020, 16'h8000, {16{8'h11}},   0,   1'b1, '0};
    vecs[12] = '{1'b0, 12'h020, 16'h0000, '0,            0,   1'b1, {8'h11, {11{8'hAA}}, {4{8'h55}}}};

    rst_n = 1'b0;
    cyc = 0; stb = 0; we = 0; adr = '0; sel = '0; wdata = '0;
    b_cyc = 0; b_stb = 0; b_we = 0; b_adr = '0; b_sel = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ack", DW'(ack), '0);
    check("reset rdata", rdata, '0);
`ifdef LINE_MEM_STATS_EN
    check("reset rd_count", DW'(rd_count), '0);
    check("reset wr_count", DW'(wr_count), '0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < NV; i++) begin
      run_txn(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdata, vecs[i].abort_at,
              ack_cnt, ack_cyc, rd);
      check($sformatf("vec%0d ack_count", i), DW'(ack_cnt), DW'(vecs[i].exp_ack ? 1 : 0));
      if (vecs[i].exp_ack) check($sformatf("vec%0d ack_cycle", i), DW'(ack_cyc), DW'(LAT));
      if (vecs[i].exp_ack && !vecs[i].we)
        check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
    end
`ifdef LINE_MEM_STATS_EN
    check("table rd_count", DW'(rd_count), DW'(exp_rd));
    check("table wr_count", DW'(wr_count), DW'(exp_wr));
`endif

    // Reset in the middle of a write to line 040
    run_txn(1'b1, 12'h040, 16'hFFFF, C040, 0, ack_cnt, ack_cyc, rd);
    run_txn(1'b0, 12'h040, 16'h0000, '0, 0, ack_cnt, ack_cyc, rd);
    check("pre-reset read 040", rd, C040);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 12'h040; sel = 16'hFFFF; wdata = DEAD;
    @(posedge clk); #1;
    stb = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midreset ack", DW'(ack), '0);
    check("midreset rdata", rdata, '0);
    exp_rd = 0; exp_wr = 0;
`ifdef LINE_MEM_STATS_EN
    check("midreset rd_count", DW'(rd_count), '0);
    check("midreset wr_count", DW'(wr_count), '0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(posedge clk); #1;
      if (ack) stray++;
    end
    cyc = 1'b0;
    check("midreset no ack", DW'(stray), '0);
    run_txn(1'b0, 12'h040, 16'h0000, '0, 0, ack_cnt, ack_cyc, rd);
    check("post-reset read 040", rd, C040);
    check("post-reset ack_cycle", DW'(ack_cyc), DW'(LAT));

    // Random traffic against the line model
    for (int i = 0; i < 8; i++) begin
      pool[i] = AW'(12'h100 + i * 17);
      run_txn(1'b1, pool[i], 16'hFFFF, rand_line(), 0, ack_cnt, ack_cyc, rd);
    end
    for (int i = 0; i < 40; i++) begin
      logic          w;
      logic [AW-1:0] a;
      logic [SW-1:0] s;
      logic [DW-1:0] d, exp_line;
      int            ab;
      w  = 1'($urandom_range(0, 1));
      a  = pool[$urandom_range(0, 7)];
      s  = SW'($urandom);
      d  = rand_line();
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, LAT)) : 0;
      exp_line = model[int'(a)];
      run_txn(w, a, s, d, ab, ack_cnt, ack_cyc, rd);
      check($sformatf("rnd%0d ack_count", i), DW'(ack_cnt), DW'(ab == 0 ? 1 : 0));
      if (ab == 0) check($sformatf("rnd%0d ack_cycle", i), DW'(ack_cyc), DW'(LAT));
      if (ab == 0 && !w) check($sformatf("rnd%0d rdata", i), rd, exp_line);
    end
    for (int i = 0; i < 8; i++) begin
      run_txn(1'b0, pool[i], 16'h0000, '0, 0, ack_cnt, ack_cyc, rd);
      check($sformatf("final read %h", pool[i]), rd, model[int'(pool[i])]);
    end
`ifdef LINE_MEM_STATS_EN
    check("final rd_count", DW'(rd_count), DW'(exp_rd));
    check("final wr_count", DW'(wr_count), DW'(exp_wr));
`endif

    // LATENCY=1 instance: cyc/stb held high, one capture every 4 edges
    b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1; b_adr = 12'h0A0; b_sel = '1;
    for (int k = 0; k < 20; k++) begin
      b_wdata = DW'(1000 + k);
      @(posedge clk); #1;
      if (b_ack) ack_pos.push_back(k);
    end
    b_cyc = 1'b0; b_stb = 1'b0;
    $display("txn b2b held stb: acks=%0d", ack_pos.size());
    check("b2b ack count", DW'(ack_pos.size()), DW'(5));
    for (int i = 0; i < ack_pos.size() && i < 5; i++)
      check($sformatf("b2b ack%0d position", i), DW'(ack_pos[i]), DW'(1 + 4 * i));
    b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b0;
    @(posedge clk); #1;
    b_stb = 1'b0;
    @(posedge clk); #1;
    $display("txn b2b read adr=0a0 ack=%0b rdata=%h", b_ack, b_rdata);
    check("b2b read ack", DW'(b_ack), DW'(1));
    check("b2b read rdata", b_rdata, DW'(1016));
    b_cyc = 1'b0;
    @(posedge clk); #1;
    check("b2b ack single pulse", DW'(b_ack), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
